// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation datapath.
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 256;
  localparam int unsigned ONE  = 1;

  typedef enum logic [2:0] {
    IDLE,
    PRE_M,
    PRE_R,
    SQR,
    MUL,
    POST,
    FIN
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

endpackage

// File: rtl/mm_reduce.sv
// Final conditional subtraction of a Montgomery product: maps 0..2N-1 onto 0..N-1.
module mm_reduce
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   mm_v_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH:0] n_ext;

  assign n_ext = {1'b0, n_i};
  assign r_o   = (mm_v_i >= n_ext) ? WIDTH'(mm_v_i - n_ext) : mm_v_i[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right binary modular exponentiation Y = M^E mod N, sequencing a
// Montgomery multiplier through a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// PRE_M | mbar = Mont(M, R2), base into Montgomery form
// PRE_R | acc  = Mont(1, R2) = R mod N
// SQR   | acc  = Mont(acc, acc)
// MUL   | acc  = Mont(acc, mbar), taken when E[k] = 1
// POST  | Y    = Mont(acc, 1), back out of Montgomery form
// FIN   | pulse done, drop busy
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] R2,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH:0]   mm_v,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y
);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mbar_q, mbar_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] mm_a_q, mm_a_d;
  logic [WIDTH-1:0] mm_b_q, mm_b_d;
  logic             mm_start_q, mm_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] mm_r;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             step_end;

  mm_reduce #(.WIDTH(WIDTH)) u_reduce (
    .mm_v_i (mm_v),
    .n_i    (n_q),
    .r_o    (mm_r)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= PH_ISSUE;
      k_q        <= '0;
      acc_q      <= '0;
      mbar_q     <= '0;
      y_q        <= '0;
      m_q        <= '0;
      e_q        <= '0;
      n_q        <= '0;
      r2_q       <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      mbar_q     <= mbar_d;
      y_q        <= y_d;
      m_q        <= m_d;
      e_q        <= e_d;
      n_q        <= n_d;
      r2_q       <= r2_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_start_q <= mm_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Operand selection per multiply state; literal ones are zero-extended.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      PRE_M:   begin op_a = m_q;          op_b = r2_q;         end
      PRE_R:   begin op_a = WIDTH'(ONE);  op_b = r2_q;         end
      SQR:     begin op_a = acc_q;        op_b = acc_q;        end
      MUL:     begin op_a = acc_q;        op_b = mbar_q;       end
      POST:    begin op_a = acc_q;        op_b = WIDTH'(ONE);  end
      default: begin op_a = '0;           op_b = '0;           end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    k_d        = k_q;
    acc_d      = acc_q;
    mbar_d     = mbar_q;
    y_d        = y_q;
    m_d        = m_q;
    e_d        = e_q;
    n_d        = n_q;
    r2_d       = r2_q;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    step_end   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = M;
          e_d     = E;
          n_d     = N;
          r2_d    = R2;
          busy_d  = 1'b1;
          state_d = PRE_M;
          phase_d = PH_ISSUE;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        phase_d = PH_ISSUE;
      end
      default: begin
        if (phase_q == PH_ISSUE) begin
          mm_a_d     = op_a;
          mm_b_d     = op_b;
          mm_start_d = 1'b1;
          phase_d    = PH_WAIT;
        end else if (mm_done) begin
          phase_d = PH_ISSUE;
          case (state_q)
            PRE_M: begin
              mbar_d  = mm_r;
              state_d = PRE_R;
            end
            PRE_R: begin
              acc_d   = mm_r;
              k_d     = CW'(WIDTH - 1);
              state_d = SQR;
            end
            SQR: begin
              acc_d = mm_r;
              if (e_q[k_q]) state_d = MUL;
              else          step_end = 1'b1;
            end
            MUL: begin
              acc_d    = mm_r;
              step_end = 1'b1;
            end
            POST: begin
              y_d     = mm_r;
              state_d = FIN;
            end
            default: ;
          endcase
        end
      end
    endcase

    // k = 0 is tested before decrementing, so k never wraps.
    if (step_end) begin
      if (k_q == '0) begin
        state_d = POST;
      end else begin
        k_d     = k_q - CW'(1);
        state_d = SQR;
      end
    end
  end

  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign Y        = y_q;

endmodule
